sram_program_loader: RTL and testbench

- Writer side of the instruction SRAM. The player core only reads 16-bit note/BPM/end words from this SRAM, starting at address 0.
- Takes a byte stream over a valid/ready handshake, e.g. from a UART receiver, and packs byte pairs big-endian into 16-bit words.
- Writes each word to consecutive SRAM addresses from 0 and stops after writing the end word (bits [15:12] == 0000).
- BUSY holds the player core and selects this block's SRAM pins in the top-level mux.

---
 rtl/sram_pkg.sv | 38 +++
 rtl/sram_write_cycle.sv | 74 +++++++
 rtl/sram_program_loader.sv | 176 +++++++++++++++++
 tb/tb_sram_program_loader.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | sram_pkg : shared widths, opcode constants and state types for SRAM loading
// | rev 1.0
// +-----------------------------------------------------------------------------
package sram_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;

  localparam logic [3:0] OP_END        = 4'b0000;
  localparam logic [3:0] OP_BPM        = 4'b0001;
  localparam int         NOTE_FLAG_BIT = 15;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GET_HI  = 3'd1,
    ST_GET_LO  = 3'd2,
    ST_SETUP   = 3'd3,
    ST_STROBE  = 3'd4,
    ST_RECOVER = 3'd5,
    ST_FINISH  = 3'd6,
    ST_FAULT   = 3'd7
  } loader_state_e;

  typedef enum logic [1:0] {
    WC_IDLE    = 2'd0,
    WC_SETUP   = 2'd1,
    WC_STROBE  = 2'd2,
    WC_RECOVER = 2'd3
  } wc_state_e;

  function automatic logic is_end_word(input logic [SRAM_DATA_W-1:0] w);
    return w[15:12] == OP_END;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_write_cycle.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | sram_write_cycle : one SETUP / STROBE / RECOVER asynchronous SRAM write
// | rev 1.0
// +-----------------------------------------------------------------------------
module sram_write_cycle
  import sram_pkg::*;
#(
  parameter int WE_CYCLES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_go,
  input  logic [SRAM_ADDR_W-1:0] i_addr,
  input  logic [SRAM_DATA_W-1:0] i_data,
  output logic                   o_busy,
  output logic                   o_strobe_last,
  output logic                   o_done,
  output logic                   o_sram_we,
  output logic [SRAM_ADDR_W-1:0] o_sram_a,
  output logic [SRAM_DATA_W-1:0] o_sram_d_out,
  output logic                   o_sram_d_oe
);

  localparam int              CNT_W  = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WE_CYCLES - 1);

  wc_state_e              r_state;
  wc_state_e              w_state_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [SRAM_ADDR_W-1:0] r_addr;
  logic [SRAM_DATA_W-1:0] r_data;
  logic                   w_active;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      WC_IDLE:    if (i_go) w_state_next = WC_SETUP;
      WC_SETUP:   w_state_next = WC_STROBE;
      WC_STROBE:  if (r_cnt == C_LAST) w_state_next = WC_RECOVER;
      WC_RECOVER: w_state_next = WC_IDLE;
      default:    w_state_next = WC_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= WC_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == WC_IDLE && i_go) begin
        r_addr <= i_addr;
        r_data <= i_data;
      end
      if (r_state == WC_STROBE) r_cnt <= r_cnt + 1'b1;
      else                      r_cnt <= '0;
    end
  end

  // Address and data stay on the bus from SETUP through RECOVER for setup/hold.
  assign w_active      = (r_state != WC_IDLE);
  assign o_busy        = w_active;
  assign o_strobe_last = (r_state == WC_STROBE) && (r_cnt == C_LAST);
  assign o_done        = (r_state == WC_RECOVER);
  assign o_sram_we     = (r_state != WC_STROBE);
  assign o_sram_d_oe   = w_active;
  assign o_sram_a      = w_active ? r_addr : '0;
  assign o_sram_d_out  = w_active ? r_data : '0;

endmodule
`default_nettype wire

// File: rtl/sram_program_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | sram_program_loader : packs a byte stream into 16-bit words written to SRAM
// | rev 1.0
// +-----------------------------------------------------------------------------
module sram_program_loader
  import sram_pkg::*;
#(
  parameter int WE_CYCLES    = 2,
  parameter int BYTE_TIMEOUT = 50000000,
  parameter int MAX_ADDR     = 262143
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_valid,
  output logic                   o_rx_ready,
  output logic                   o_sram_we,
  output logic                   o_sram_ce,
  output logic                   o_sram_oe,
  output logic                   o_sram_lb,
  output logic                   o_sram_ub,
  output logic [SRAM_ADDR_W-1:0] o_sram_a,
  output logic [SRAM_DATA_W-1:0] o_sram_d_out,
  output logic                   o_sram_d_oe,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  output logic [SRAM_ADDR_W-1:0] o_word_count
);

  localparam int                     TO_W       = $clog2(BYTE_TIMEOUT + 1);
  localparam logic [TO_W-1:0]        C_TO_LAST  = TO_W'(BYTE_TIMEOUT - 1);
  localparam logic [SRAM_ADDR_W-1:0] C_MAX_ADDR = SRAM_ADDR_W'(MAX_ADDR);

  loader_state_e          r_state;
  loader_state_e          w_state_next;
  logic [7:0]             r_hi;
  logic [SRAM_ADDR_W-1:0] r_addr;
  logic [SRAM_ADDR_W-1:0] r_word_count;
  logic [TO_W-1:0]        r_to_cnt;
  logic                   r_done;
  logic                   r_err;

  logic                   w_accept;
  logic                   w_go;
  logic                   w_busy;
  logic                   w_clear;
  logic                   w_set_done;
  logic                   w_set_err;
  logic                   w_inc_addr;
  logic                   w_inc_count;
  logic                   w_wc_busy;
  logic                   w_wc_strobe_last;
  logic                   w_wc_done;
  logic [SRAM_DATA_W-1:0] w_wc_data;

  assign o_rx_ready = (r_state == ST_GET_HI) || (r_state == ST_GET_LO);
  assign w_accept   = i_rx_valid && o_rx_ready;
  assign w_go       = (r_state == ST_GET_LO) && w_accept;
  assign w_busy     = (r_state == ST_GET_HI) || (r_state == ST_GET_LO) ||
                      (r_state == ST_SETUP)  || (r_state == ST_STROBE) ||
                      (r_state == ST_RECOVER);

  // The write engine latches {high byte, incoming low byte} on the accepting edge.
  sram_write_cycle #(
    .WE_CYCLES (WE_CYCLES)
  ) u_write_cycle (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_go          (w_go),
    .i_addr        (r_addr),
    .i_data        ({r_hi, i_rx_data}),
    .o_busy        (w_wc_busy),
    .o_strobe_last (w_wc_strobe_last),
    .o_done        (w_wc_done),
    .o_sram_we     (o_sram_we),
    .o_sram_a      (o_sram_a),
    .o_sram_d_out  (w_wc_data),
    .o_sram_d_oe   (o_sram_d_oe)
  );

  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_set_done   = 1'b0;
    w_set_err    = 1'b0;
    w_inc_addr   = 1'b0;
    w_inc_count  = 1'b0;
    case (r_state)
      ST_IDLE, ST_FINISH, ST_FAULT: begin
        if (i_start) begin
          w_clear      = 1'b1;
          w_state_next = ST_GET_HI;
        end
      end
      ST_GET_HI: begin
        if (w_accept) w_state_next = ST_GET_LO;
      end
      ST_GET_LO: begin
        if (w_accept) begin
          w_state_next = ST_SETUP;
        end else if (r_to_cnt == C_TO_LAST) begin
          w_set_err    = 1'b1;
          w_state_next = ST_FAULT;
        end
      end
      ST_SETUP: begin
        if (w_wc_busy) w_state_next = ST_STROBE;
      end
      ST_STROBE: begin
        if (w_wc_strobe_last) w_state_next = ST_RECOVER;
      end
      ST_RECOVER: begin
        if (w_wc_done) begin
          w_inc_count = 1'b1;
          if (is_end_word(w_wc_data)) begin
            w_set_done   = 1'b1;
            w_state_next = ST_FINISH;
          end else if (r_addr == C_MAX_ADDR) begin
            w_set_err    = 1'b1;
            w_state_next = ST_FAULT;
          end else begin
            w_inc_addr   = 1'b1;
            w_state_next = ST_GET_HI;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_hi         <= '0;
      r_addr       <= '0;
      r_word_count <= '0;
      r_to_cnt     <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_clear) begin
        r_addr       <= '0;
        r_word_count <= '0;
        r_to_cnt     <= '0;
        r_done       <= 1'b0;
        r_err        <= 1'b0;
      end
      if (r_state == ST_GET_HI && w_accept) begin
        r_hi     <= i_rx_data;
        r_to_cnt <= '0;
      end
      // Counter stops at BYTE_TIMEOUT because GET_LO is left on that edge.
      if (r_state == ST_GET_LO && !w_accept) r_to_cnt <= r_to_cnt + 1'b1;
      if (w_inc_addr)  r_addr       <= r_addr + 1'b1;
      if (w_inc_count) r_word_count <= r_word_count + 1'b1;
      if (w_set_done)  r_done       <= 1'b1;
      if (w_set_err)   r_err        <= 1'b1;
    end
  end

  assign o_busy       = w_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_word_count = r_word_count;
  assign o_sram_d_out = w_wc_data;
  assign o_sram_ce    = ~w_busy;
  assign o_sram_lb    = ~w_busy;
  assign o_sram_ub    = ~w_busy;
  assign o_sram_oe    = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_sram_program_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_sram_program_loader : directed bench with a word-level model of the load
// | rev 1.0
// +-----------------------------------------------------------------------------
module tb_sram_program_loader;

  localparam int P_WE  = 2;
  localparam int P_TO  = 100;
  localparam int P_MAX = 3;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_valid = 1'b0;
  logic        o_rx_ready, o_sram_we, o_sram_ce, o_sram_oe, o_sram_lb, o_sram_ub;
  logic [17:0] o_sram_a;
  logic [15:0] o_sram_d_out;
  logic        o_sram_d_oe, o_busy, o_done, o_err;
  logic [17:0] o_word_count;

  sram_program_loader #(
    .WE_CYCLES    (P_WE),
    .BYTE_TIMEOUT (P_TO),
    .MAX_ADDR     (P_MAX)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_rx_ready   (o_rx_ready),
    .o_sram_we    (o_sram_we),
    .o_sram_ce    (o_sram_ce),
    .o_sram_oe    (o_sram_oe),
    .o_sram_lb    (o_sram_lb),
    .o_sram_ub    (o_sram_ub),
    .o_sram_a     (o_sram_a),
    .o_sram_d_out (o_sram_d_out),
    .o_sram_d_oe  (o_sram_d_oe),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err),
    .o_word_count (o_word_count)
  );

  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [7:0]  stim [0:15];
  int          n_stim;
  logic [33:0] exp_q [$];
  int          exp_wc;
  logic        exp_done, exp_err;
  logic [15:0] mem [0:3];
  int          we_lo = 0;
  int          we_total = 0;
  logic [17:0] pa;
  logic [15:0] pd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Word-level model: pair bytes, number them from 0, stop at end word or last address.
  task automatic model_load();
    int addr;
    logic [15:0] w;
    addr = 0; exp_wc = 0; exp_done = 1'b0; exp_err = 1'b0;
    for (int i = 0; i + 1 < n_stim; i += 2) begin
      w = {stim[i], stim[i+1]};
      exp_q.push_back({addr[17:0], w});
      exp_wc++;
      if (w[15:12] == 4'h0) begin exp_done = 1'b1; break; end
      if (addr == P_MAX) begin exp_err = 1'b1; break; end
      addr++;
    end
  endtask

  // Monitor: pin relationships every cycle, and every completed WE pulse against the model.
  always @(negedge clk) begin
    if (!i_rst_n) begin
      we_lo = 0;
    end else begin
      check("done_err_excl", o_done && o_err, 1'b0);
      check("ready_while_driving", o_rx_ready && o_sram_d_oe, 1'b0);
      if (o_busy)
        check("busy_pins", {o_sram_ce, o_sram_oe, o_sram_lb, o_sram_ub}, 4'b0100);
      else
        check("idle_pins", {o_sram_we, o_sram_ce, o_sram_oe, o_sram_lb, o_sram_ub,
                            o_sram_d_oe, o_rx_ready, o_sram_a, o_sram_d_out},
              {7'b1111100, 18'h0, 16'h0});
      if (!o_sram_we) begin
        if (we_lo == 0) begin
          pa = o_sram_a;
          pd = o_sram_d_out;
        end else begin
          check("strobe_addr_stable", o_sram_a, pa);
          check("strobe_data_stable", o_sram_d_out, pd);
        end
        check("strobe_d_oe", o_sram_d_oe, 1'b1);
        we_lo++;
        we_total++;
      end else if (we_lo != 0) begin
        check("we_pulse_len", we_lo, P_WE);
        check("hold_addr", o_sram_a, pa);
        check("hold_data", o_sram_d_out, pd);
        check("hold_d_oe", o_sram_d_oe, 1'b1);
        check("write_addr_range", o_sram_a <= P_MAX, 1'b1);
        mem[o_sram_a[1:0]] = o_sram_d_out;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1'b1, 1'b0);
        end else begin
          check("write_addr", o_sram_a, exp_q[0][33:16]);
          check("write_data", o_sram_d_out, exp_q[0][15:0]);
          void'(exp_q.pop_front());
        end
        we_lo = 0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    logic acc;
    t = 0;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    forever begin
      acc = o_rx_ready;
      @(posedge clk);
      if (acc) break;
      if (t >= 2000) begin
        check("byte_accept_timeout", 1'b0, 1'b1);
        break;
      end
      @(negedge clk);
      t++;
    end
  endtask

  task automatic send_all(input int gap);
    for (int i = 0; i < n_stim; i++) begin
      @(negedge clk);
      send_byte(stim[i]);
      if (gap > 0) begin
        @(negedge clk);
        i_rx_valid = 1'b0;
        repeat (gap - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (o_busy && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout", o_busy, 1'b0);
  endtask

  task automatic pulse_start();
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4; i++) mem[i] = 16'hDEAD;
  endtask

  task automatic run_load(input int gap);
    model_load();
    pulse_start();
    check("start_busy", o_busy, 1'b1);
    check("start_clears", {o_done, o_err, o_word_count}, 20'h0);
    send_all(gap);
    wait_idle();
    check("word_count", o_word_count, exp_wc);
    check("done", o_done, exp_done);
    check("err", o_err, exp_err);
    check("writes_outstanding", exp_q.size(), 0);
  endtask

  task automatic set_stim4(input logic [7:0] b0, b1, b2, b3);
    stim[0] = b0; stim[1] = b1; stim[2] = b2; stim[3] = b3;
    n_stim = 4;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int we_before;
    int t;
    clear_mem();
    repeat (3) @(negedge clk);
    i_rst_n = 1'b1;
    @(negedge clk);
    check("reset_pins", {o_sram_we, o_sram_ce, o_sram_oe, o_sram_lb, o_sram_ub, o_sram_d_oe,
                         o_sram_a, o_sram_d_out},
          {6'b111110, 18'h0, 16'h0});
    check("reset_status", {o_rx_ready, o_busy, o_done, o_err, o_word_count}, 22'h0);

    // Back-to-back bytes, RX_VALID held across the write.
    set_stim4(8'h80, 8'h15, 8'h00, 8'h00);
    run_load(0);
    check("t1_mem0", mem[0], 16'h8015);
    check("t1_mem1", mem[1], 16'h0000);
    check("t1_status", {o_word_count, o_done, o_busy}, {18'd2, 1'b1, 1'b0});

    // Same stream with idle gaps; START from FINISH clears DONE/WORD_COUNT.
    clear_mem();
    run_load(10);
    check("t2_mem0", mem[0], 16'h8015);
    check("t2_mem1", mem[1], 16'h0000);

    // Low byte never arrives.
    pulse_start();
    we_before = we_total;
    @(negedge clk);
    send_byte(8'h80);
    #1 i_rx_valid = 1'b0;
    k = 0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      k = c;
      if (o_err) break;
    end
    check("timeout_cycle", k, 100);
    check("timeout_err", o_err, 1'b1);
    @(negedge clk);
    check("timeout_no_we", we_total - we_before, 0);
    check("timeout_status", {o_word_count, o_done, o_busy}, 20'h0);

    // Four note words, no end word: address ceiling.
    clear_mem();
    stim[0] = 8'h90; stim[1] = 8'h01; stim[2] = 8'h91; stim[3] = 8'h02;
    stim[4] = 8'h92; stim[5] = 8'h03; stim[6] = 8'h93; stim[7] = 8'h04;
    n_stim = 8;
    run_load(0);
    check("t4_mem0", mem[0], 16'h9001);
    check("t4_mem3", mem[3], 16'h9304);
    check("t4_status", {o_word_count, o_err, o_done}, {18'd4, 1'b1, 1'b0});

    // Reset during STROBE.
    pulse_start();
    @(negedge clk); send_byte(8'h91);
    @(negedge clk); send_byte(8'h23);
    t = 0;
    @(negedge clk);
    while (o_sram_we && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("saw_strobe", o_sram_we, 1'b0);
    i_rst_n = 1'b0;
    i_rx_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_we", o_sram_we, 1'b1);
    check("rst_d_oe", o_sram_d_oe, 1'b0);
    check("rst_idle", {o_busy, o_rx_ready, o_done, o_err, o_word_count}, 22'h0);
    @(negedge clk);
    i_rst_n = 1'b1;
    exp_q.delete();
    clear_mem();
    set_stim4(8'h91, 8'h23, 8'h00, 8'h05);
    run_load(0);
    check("t5_mem0", mem[0], 16'h9123);
    check("t5_mem1", mem[1], 16'h0005);

    // START while waiting for the low byte is ignored.
    clear_mem();
    set_stim4(8'hA0, 8'h01, 8'h00, 8'h00);
    model_load();
    pulse_start();
    @(negedge clk); send_byte(stim[0]);
    @(negedge clk);
    i_rx_valid = 1'b0;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("start_in_get_lo", {o_busy, o_rx_ready}, 2'b11);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      send_byte(stim[i]);
    end
    @(negedge clk);
    i_rx_valid = 1'b0;
    wait_idle();
    check("t6_mem0", mem[0], 16'hA001);
    check("t6_status", {o_word_count, o_done, o_err}, {18'd2, 1'b1, 1'b0});
    check("t6_outstanding", exp_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
